// File: rtl/boreal_ledger_writer_pkg.sv
// boreal_ledger_writer_pkg: shared ledger word layout, FSM states and chain rotate helper
package boreal_ledger_writer_pkg;
    localparam int LEDGER_WORDS      = 8;
    localparam int LEDGER_SEQ_WIDX   = 7;
    localparam int LEDGER_CHAIN_WIDX = 6;
    localparam int LEDGER_ROT        = 5;
    typedef enum logic [1:0] {LW_IDLE, LW_LOAD, LW_WRITE, LW_COMMIT} lw_state_t;
    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << LEDGER_ROT) | (x >> (32 - LEDGER_ROT));
    endfunction
endpackage

// File: rtl/boreal_evt_fifo.sv
// boreal_evt_fifo: sync event FIFO; full/empty from an occupancy counter, output read from storage registers
module boreal_evt_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clear) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push && !clear) mem[wp] <= din;
endmodule

// File: rtl/boreal_ledger_writer.sv
// boreal_ledger_writer: buffers ledger events and writes each as 8 stamped words into a circular RAM.
// Define BOREAL_LEDGER_CHAIN_EN to compute the running chain digest into word 6.
module boreal_ledger_writer
    import boreal_ledger_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEDGER_ENTRIES = 256,
    localparam int LW = $clog2(LEDGER_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          led_wr,
    input  logic [255:0]  led_event,
    output logic          mem_we,
    output logic [LW+2:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic [LW-1:0] head_idx,
    output logic [31:0]   seq_out,
    output logic [31:0]   chain_out,
    output logic [31:0]   drop_ctr,
    output logic          overflow,
    output logic          busy
);
    lw_state_t state, state_nx;
    logic [255:0] fifo_dout;
    logic fifo_full, fifo_empty, push, drop;
    logic [31:0] wb [LEDGER_WORDS];
    logic [2:0] beat;
    assign push      = led_wr && !fifo_full && !clear;
    assign drop      = led_wr && fifo_full && !clear;
    assign busy      = !fifo_empty || state != LW_IDLE;
    assign mem_addr  = {head_idx, beat};
    assign mem_wdata = wb[beat];
    boreal_evt_fifo #(.WIDTH(256), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (state == LW_LOAD),
        .din   (led_event),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= LW_IDLE;
        else state <= state_nx;
    // IDLE also looks at the incoming push so LOAD follows the strobe cycle directly.
    always_comb begin
        state_nx = clear ? LW_IDLE :
                   state == LW_IDLE  ? ((!fifo_empty || push) ? LW_LOAD : LW_IDLE) :
                   state == LW_LOAD  ? LW_WRITE :
                   state == LW_WRITE ? ((mem_ready && beat == 3'(LEDGER_WORDS - 1)) ? LW_COMMIT : LW_WRITE) :
                   LW_IDLE;
        mem_we = state == LW_WRITE;
    end
`ifdef BOREAL_LEDGER_CHAIN_EN
    logic [31:0] chain_nx;
    always_comb begin
        chain_nx = rotl(chain_out) ^ seq_out;
        for (int k = 0; k < LEDGER_CHAIN_WIDX; k++) chain_nx = chain_nx ^ fifo_dout[32*k +: 32];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) chain_out <= '0;
        else if (clear) chain_out <= '0;
        else if (state == LW_COMMIT) chain_out <= wb[LEDGER_CHAIN_WIDX];
`else
    assign chain_out = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat     <= '0;
            seq_out  <= '0;
            head_idx <= '0;
            drop_ctr <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < LEDGER_WORDS; k++) wb[k] <= '0;
        end else if (clear) begin
            beat     <= '0;
            seq_out  <= '0;
            head_idx <= '0;
            drop_ctr <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (drop && drop_ctr != '1) drop_ctr <= drop_ctr + 1'b1;
            if (state == LW_LOAD) begin
                for (int k = 0; k < LEDGER_WORDS; k++) wb[k] <= fifo_dout[32*k +: 32];
                wb[LEDGER_SEQ_WIDX] <= seq_out;
`ifdef BOREAL_LEDGER_CHAIN_EN
                wb[LEDGER_CHAIN_WIDX] <= chain_nx;
`endif
                beat <= '0;
            end
            if (state == LW_WRITE && mem_ready && beat != 3'(LEDGER_WORDS - 1)) beat <= beat + 1'b1;
            if (state == LW_COMMIT) begin
                seq_out  <= seq_out + 1'b1;
                head_idx <= head_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_boreal_ledger_writer.sv
// tb_boreal_ledger_writer: randomized scenarios checked against a queue-based ledger model (4-entry ledger)
module tb_boreal_ledger_writer;
`ifdef BOREAL_LEDGER_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, led_wr = 1'b0, mem_ready = 1'b1;
    logic [255:0] led_event = '0;
    logic mem_we, overflow, busy;
    logic [4:0] mem_addr;
    logic [1:0] head_idx;
    logic [31:0] mem_wdata, seq_out, chain_out, drop_ctr;
    int n_chk = 0, n_fail = 0;
    logic [36:0] wr_q[$], exp_q[$];
    logic [31:0] m_seq = '0, m_chain = '0;
    logic [1:0] m_head = '0;

    boreal_ledger_writer #(.FIFO_DEPTH(4), .LEDGER_ENTRIES(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .led_wr(led_wr), .led_event(led_event),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .head_idx(head_idx), .seq_out(seq_out), .chain_out(chain_out), .drop_ctr(drop_ctr),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rst_n && mem_we && mem_ready) wr_q.push_back({mem_addr, mem_wdata});

    function automatic logic [255:0] rand_event();
        logic [255:0] e;
        for (int k = 0; k < 8; k++) e[32*k +: 32] = $urandom;
        return e;
    endfunction

    // Ledger model: the 8 words an event must produce, then advance seq/chain/head.
    function automatic void model_entry(input logic [255:0] e);
        logic [31:0] x;
        x = {m_chain[26:0], m_chain[31:27]} ^ m_seq;
        for (int k = 0; k < 6; k++) x = x ^ e[32*k +: 32];
        for (int k = 0; k < 8; k++)
            exp_q.push_back({m_head, 3'(k), k == 7 ? m_seq : (k == 6 && CHAIN) ? x : e[32*k +: 32]});
        if (CHAIN) m_chain = x;
        m_seq = m_seq + 1;
        m_head = m_head + 1;
    endfunction

    function automatic void model_clear();
        m_seq = '0; m_chain = '0; m_head = '0;
        wr_q.delete(); exp_q.delete();
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({mem_we, mem_addr, mem_wdata, head_idx, seq_out, chain_out, drop_ctr, overflow, busy} !== '0) begin
            n_fail++; $display("FAIL reset_hold: outputs not all zero (we=%b addr=%h seq=%h busy=%b)", mem_we, mem_addr, seq_out, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({mem_we, mem_addr, mem_wdata, head_idx, seq_out, chain_out, drop_ctr, overflow, busy} !== '0) begin
            n_fail++; $display("FAIL reset_release: outputs not all zero (we=%b addr=%h seq=%h busy=%b)", mem_we, mem_addr, seq_out, busy);
        end
    endtask

    task automatic test_single(input string name);
        logic [255:0] e;
        int n;
        e = rand_event();
        for (int k = 0; k < 6; k++) e[32*k +: 32] = 32'(k + 1);
        led_wr = 1'b1; led_event = e;
        @(negedge clk); led_wr = 1'b0; n = 1;
        n_chk++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL %s load_cycle_we: got %b, expected 0", name, mem_we); end
        @(negedge clk); n++;
        n_chk++;
        if (mem_we !== 1'b1) begin n_fail++; $display("FAIL %s first_we_latency: got %b, expected 1", name, mem_we); end
        while (busy && n < 40) begin @(negedge clk); n++; end
        n_chk++;
        if (n != 11) begin n_fail++; $display("FAIL %s entry_cycles: got %0d, expected 11", name, n); end
        model_entry(e);
        n_chk++;
        if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL %s write_count: got %0d, expected %0d", name, wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_chk++;
            if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s word%0d: got %h, expected %h", name, i, wr_q[i], exp_q[i]); end
        end
        wr_q.delete(); exp_q.delete();
        n_chk++;
        if ({seq_out, head_idx, chain_out} !== {m_seq, m_head, m_chain}) begin
            n_fail++; $display("FAIL %s status: got seq=%0d head=%0d chain=%h, expected seq=%0d head=%0d chain=%h", name, seq_out, head_idx, chain_out, m_seq, m_head, m_chain);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] e;
        logic [4:0] a;
        logic [31:0] d;
        int n;
        e = rand_event();
        led_wr = 1'b1; led_event = e;
        @(negedge clk); led_wr = 1'b0; n = 1;
        while (!(mem_we && mem_addr[2:0] == 3'd4) && n < 20) begin @(negedge clk); n++; end
        mem_ready = 1'b0; a = mem_addr; d = mem_wdata;
        repeat (3) begin
            @(negedge clk); n++;
            n_chk++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a, d}) begin
                n_fail++; $display("FAIL bp_hold: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h", mem_we, mem_addr, mem_wdata, a, d);
            end
        end
        mem_ready = 1'b1;
        while (busy && n < 60) begin @(negedge clk); n++; end
        n_chk++;
        if (n != 14) begin n_fail++; $display("FAIL bp_entry_cycles: got %0d, expected 14", n); end
        model_entry(e);
        n_chk++;
        if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp write_count: got %0d, expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_chk++;
            if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp word%0d: got %h, expected %h", i, wr_q[i], exp_q[i]); end
        end
        wr_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [255:0] ev[5];
        int n, c;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < 5; k++) ev[k] = rand_event();
            for (c = 0; c < 200; c++) begin
                @(negedge clk);
                if (c >= n && !busy) break;
                led_wr = c < n;
                led_event = ev[c % 5];
                mem_ready = $urandom_range(0, 3) != 0;
            end
            led_wr = 1'b0; mem_ready = 1'b1;
            for (int k = 0; k < n; k++) model_entry(ev[k]);
            n_chk++;
            if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d write_count: got %0d, expected %0d", r, wr_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
                n_chk++;
                if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d word%0d: got %h, expected %h", r, i, wr_q[i], exp_q[i]); end
            end
            wr_q.delete(); exp_q.delete();
            n_chk++;
            if ({seq_out, head_idx, chain_out, drop_ctr} !== {m_seq, m_head, m_chain, 32'd0}) begin
                n_fail++; $display("FAIL rand%0d status: got seq=%0d head=%0d chain=%h drops=%0d, expected seq=%0d head=%0d chain=%h drops=0", r, seq_out, head_idx, chain_out, drop_ctr, m_seq, m_head, m_chain);
            end
        end
    endtask

    task automatic test_overflow();
        logic [255:0] ev[6];
        int n;
        mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ev[k] = rand_event();
            @(negedge clk); led_wr = 1'b1; led_event = ev[k];
        end
        @(negedge clk); led_wr = 1'b0;
        n_chk++;
        if ({drop_ctr, overflow} !== {32'd1, 1'b1}) begin
            n_fail++; $display("FAIL ovf_status: got drops=%0d ovf=%b, expected drops=1 ovf=1", drop_ctr, overflow);
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if ({mem_we, mem_addr[2:0], 32'(wr_q.size())} !== {1'b1, 3'd0, 32'd0}) begin
            n_fail++; $display("FAIL ovf_stall: got we=%b beat=%0d writes=%0d, expected we=1 beat=0 writes=0", mem_we, mem_addr[2:0], wr_q.size());
        end
        mem_ready = 1'b1; n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        n_chk++;
        if (busy) begin n_fail++; $display("FAIL ovf_drain: got busy=1 after %0d cycles, expected idle", n); end
        for (int k = 0; k < 5; k++) model_entry(ev[k]);
        n_chk++;
        if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf write_count: got %0d, expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_chk++;
            if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf word%0d: got %h, expected %h", i, wr_q[i], exp_q[i]); end
        end
        wr_q.delete(); exp_q.delete();
        n_chk++;
        if ({seq_out, drop_ctr, overflow} !== {m_seq, 32'd1, 1'b1}) begin
            n_fail++; $display("FAIL ovf_final: got seq=%0d drops=%0d ovf=%b, expected seq=%0d drops=1 ovf=1", seq_out, drop_ctr, overflow, m_seq);
        end
    endtask

    task automatic test_clear();
        logic [255:0] e;
        int n;
        led_wr = 1'b1; led_event = rand_event();
        @(negedge clk); led_wr = 1'b0; n = 0;
        while (!(mem_we && mem_addr[2:0] == 3'd3) && n < 20) begin @(negedge clk); n++; end
        clear = 1'b1; led_wr = 1'b1; led_event = rand_event();
        @(negedge clk); clear = 1'b0; led_wr = 1'b0;
        n_chk++;
        if ({mem_we, seq_out, head_idx, chain_out, drop_ctr, overflow, busy} !== '0) begin
            n_fail++; $display("FAIL clear_state: got we=%b seq=%0d head=%0d chain=%h drops=%0d ovf=%b busy=%b, expected all 0", mem_we, seq_out, head_idx, chain_out, drop_ctr, overflow, busy);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if ({mem_we, busy} !== 2'b00) begin n_fail++; $display("FAIL clear_discard: got we=%b busy=%b, expected 0 0", mem_we, busy); end
        model_clear();
        e = rand_event();
        led_wr = 1'b1; led_event = e;
        @(negedge clk); led_wr = 1'b0; n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        model_entry(e);
        n_chk++;
        if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clr write_count: got %0d, expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_chk++;
            if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clr word%0d: got %h, expected %h", i, wr_q[i], exp_q[i]); end
        end
        wr_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        logic [255:0] ev[5];
        int n;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_clear();
        for (int k = 0; k < 5; k++) begin
            ev[k] = rand_event();
            led_wr = 1'b1; led_event = ev[k];
            @(negedge clk);
        end
        led_wr = 1'b0; n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) model_entry(ev[k]);
        n_chk++;
        if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap write_count: got %0d, expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_chk++;
            if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap word%0d: got %h, expected %h", i, wr_q[i], exp_q[i]); end
        end
        n_chk++;
        if (wr_q.size() == 40 && wr_q[32][36:32] !== 5'd0) begin n_fail++; $display("FAIL wrap_fifth_addr: got %h, expected 00", wr_q[32][36:32]); end
        wr_q.delete(); exp_q.delete();
        n_chk++;
        if ({head_idx, seq_out} !== {2'd1, 32'd5}) begin
            n_fail++; $display("FAIL wrap_status: got head=%0d seq=%0d, expected head=1 seq=5", head_idx, seq_out);
        end
    endtask

    initial begin
        test_reset();
        test_single("single");
        test_single("second");
        test_backpressure();
        test_random();
        test_overflow();
        test_clear();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
